// File: rtl/led_chaser_multi.sv
// LED chaser for N_LEDS board LEDs: a clock divider paces four selectable
// chase patterns, and STEP marks each cycle in which LEDR changes.
module led_chaser_multi #(
    parameter int N_LEDS = 8,
    parameter int DIV    = 50000000
) (
    input  logic              CLOCK_50,
    input  logic              RESET,
    input  logic              EN,
    input  logic [1:0]        MODE,
    output logic [N_LEDS-1:0] LEDR,
    output logic              STEP
);

    localparam int H  = N_LEDS / 2;
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PW = $clog2(N_LEDS);

    typedef enum logic [2:0] {
        M_OUT_IN = 3'd0,
        M_IN_OUT = 3'd1,
        M_BOUNCE = 3'd2,
        M_ROTATE = 3'd3,
        M_NONE   = 3'd4
    } mode_t;

    logic [CW-1:0]     cnt;
    logic              tick;
    mode_t             active;
    mode_t             req_mode;
    mode_t             nxt_active;
    logic [PW-1:0]     pos;
    logic [PW-1:0]     nxt_pos;
    logic              dir_up;
    logic              nxt_dir;
    logic [N_LEDS-1:0] nxt_led;

    function automatic logic [N_LEDS-1:0] pair_mask(input logic [PW-1:0] p);
        logic [N_LEDS-1:0] m;
        int                lo;
        m  = '0;
        lo = int'(p);
        m[lo]            = 1'b1;
        m[N_LEDS-1-lo]   = 1'b1;
        return m;
    endfunction

    assign tick     = EN && (cnt == CW'(DIV - 1));
    assign req_mode = mode_t'({1'b0, MODE});

    always_comb begin
        nxt_active = active;
        nxt_pos    = pos;
        nxt_dir    = dir_up;
        // M_NONE never equals a requested mode, so the first tick always restarts.
        if (req_mode != active) begin
            nxt_active = req_mode;
            nxt_dir    = 1'b1;
            nxt_pos    = (req_mode == M_IN_OUT) ? PW'(H - 1) : '0;
        end else begin
            case (active)
                M_OUT_IN: nxt_pos = (pos == PW'(H - 1)) ? '0 : pos + 1'b1;
                M_IN_OUT: nxt_pos = (pos == '0) ? PW'(H - 1) : pos - 1'b1;
                M_BOUNCE: begin
                    // Turn around on arrival so each end is shown only once per pass.
                    if (dir_up) begin
                        nxt_pos = pos + 1'b1;
                        nxt_dir = (nxt_pos != PW'(H - 1));
                    end else begin
                        nxt_pos = pos - 1'b1;
                        nxt_dir = (nxt_pos == '0);
                    end
                end
                M_ROTATE: nxt_pos = (pos == PW'(N_LEDS - 1)) ? '0 : pos + 1'b1;
                default:  nxt_pos = pos;
            endcase
        end
        if (nxt_active == M_ROTATE)
            nxt_led = {{(N_LEDS-1){1'b0}}, 1'b1} << nxt_pos;
        else
            nxt_led = pair_mask(nxt_pos);
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            cnt    <= '0;
            STEP   <= 1'b0;
            LEDR   <= '0;
            active <= M_NONE;
            pos    <= '0;
            dir_up <= 1'b1;
        end else begin
            STEP <= tick;
            if (EN)
                cnt <= tick ? '0 : cnt + 1'b1;
            if (tick) begin
                active <= nxt_active;
                pos    <= nxt_pos;
                dir_up <= nxt_dir;
                LEDR   <= nxt_led;
            end
        end
    end

endmodule

// File: tb/tb_led_chaser_multi.sv
// Directed bench for led_chaser_multi with N_LEDS = 8, DIV = 4: pattern
// sequences, tick spacing, mode switch, pause and asynchronous reset.
module tb_led_chaser_multi;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [7:0] ledr;
    logic       step;

    int n_cmp = 0;
    int n_err = 0;

    led_chaser_multi #(.N_LEDS(8), .DIV(4)) dut (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .EN       (en),
        .MODE     (mode),
        .LEDR     (ledr),
        .STEP     (step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Count edges until STEP is seen (sampled on falling edges), then check spacing and LEDR.
    task automatic next_tick(input string tag, input int exp_gap, input logic [7:0] exp_led);
        int gap;
        gap = 0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (step) begin
                gap = i;
                break;
            end
        end
        check({tag, "_gap"}, gap, exp_gap);
        check({tag, "_led"}, ledr, exp_led);
    endtask

    task automatic do_reset(input logic [1:0] m);
        @(negedge clk);
        rst  = 1'b1;
        en   = 1'b1;
        mode = m;
        repeat (2) @(negedge clk);
        check("rst_led", ledr, 8'h00);
        check("rst_step", step, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_led;
        rst  = 1'b1;
        en   = 1'b0;
        mode = 2'd0;

        // Outside-in
        do_reset(2'd0);
        next_tick("m0_t0", 4, 8'b10000001);
        next_tick("m0_t1", 4, 8'b01000010);
        next_tick("m0_t2", 4, 8'b00100100);
        next_tick("m0_t3", 4, 8'b00011000);
        next_tick("m0_t4", 4, 8'b10000001);

        // Inside-out
        do_reset(2'd1);
        next_tick("m1_t0", 4, 8'b00011000);
        next_tick("m1_t1", 4, 8'b00100100);
        next_tick("m1_t2", 4, 8'b01000010);
        next_tick("m1_t3", 4, 8'b10000001);
        next_tick("m1_t4", 4, 8'b00011000);

        // Bounce
        do_reset(2'd2);
        next_tick("m2_t0", 4, 8'b10000001);
        next_tick("m2_t1", 4, 8'b01000010);
        next_tick("m2_t2", 4, 8'b00100100);
        next_tick("m2_t3", 4, 8'b00011000);
        next_tick("m2_t4", 4, 8'b00100100);
        next_tick("m2_t5", 4, 8'b01000010);
        next_tick("m2_t6", 4, 8'b10000001);
        next_tick("m2_t7", 4, 8'b01000010);

        // Rotate, including wrap back to LED 0
        do_reset(2'd3);
        for (int k = 0; k <= 8; k++) begin
            exp_led = 8'h01 << (k % 8);
            next_tick($sformatf("m3_t%0d", k), 4, exp_led);
        end

        // Mode change two cycles before a tick
        do_reset(2'd0);
        next_tick("chg_t0", 4, 8'b10000001);
        next_tick("chg_t1", 4, 8'b01000010);
        next_tick("chg_t2", 4, 8'b00100100);
        repeat (2) @(negedge clk);
        mode = 2'd3;
        @(negedge clk);
        check("chg_hold_led", ledr, 8'b00100100);
        check("chg_hold_step", step, 1'b0);
        next_tick("chg_load", 1, 8'b00000001);
        next_tick("chg_adv", 4, 8'b00000010);

        // Pause with count at DIV-1, then reset mid-period
        do_reset(2'd0);
        next_tick("en_t0", 4, 8'b10000001);
        repeat (3) @(negedge clk);
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check($sformatf("pause_led%0d", k), ledr, 8'b10000001);
            check($sformatf("pause_step%0d", k), step, 1'b0);
        end
        en = 1'b1;
        next_tick("resume", 1, 8'b01000010);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_rst_led", ledr, 8'h00);
        check("async_rst_step", step, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        next_tick("post_rst", 4, 8'b10000001);
        next_tick("post_rst2", 4, 8'b01000010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
